// File: rtl/operands_pkg.sv
// Shared widths, dimension helpers and state encoding for the operand read path.
// Imported by the reader, its row buffer and the bus interface.
package operands_pkg;

  localparam int OPR_DATA_WIDTH = 32;
  localparam int OPR_BUS_WIDTH  = 64;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_CHECK  = 3'd2,
    ST_STREAM = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  function automatic int max_dim(input int data_w, input int bus_w);
    return bus_w / data_w;
  endfunction

  // A dimension of 0 or anything above the store capacity means "full matrix".
  function automatic int clamp_dim(input int dim, input int max_d);
    return ((dim == 0) || (dim > max_d)) ? max_d : dim;
  endfunction

endpackage

// File: rtl/operand_reader_if.sv
// Store-side send handshake plus the element stream toward the datapath.
// master = operand_reader, slave = store/datapath side.
interface operand_reader_if import operands_pkg::*; #(
  parameter int DATA_WIDTH = OPR_DATA_WIDTH,
  parameter int BUS_WIDTH  = OPR_BUS_WIDTH
) ();
  localparam int MAX_DIM = max_dim(DATA_WIDTH, BUS_WIDTH);
  localparam int IDX_W   = $clog2(MAX_DIM);

  logic                  start_send_o;
  logic [BUS_WIDTH-1:0]  op_data_i;
  logic                  finish_send_i;
  logic                  elem_valid_o;
  logic                  elem_ready_i;
  logic [DATA_WIDTH-1:0] elem_o;
  logic [IDX_W-1:0]      elem_row_o;
  logic [IDX_W-1:0]      elem_col_o;

  modport master (
    output start_send_o, input op_data_i, input finish_send_i,
    output elem_valid_o, input elem_ready_i,
    output elem_o, output elem_row_o, output elem_col_o
  );

  modport slave (
    input start_send_o, output op_data_i, output finish_send_i,
    input elem_valid_o, output elem_ready_i,
    input elem_o, input elem_row_o, input elem_col_o
  );
endinterface

// File: rtl/operand_row_buffer.sv
// Captures one store row per enabled slot and exposes element (row, col)
// through a lane mux; lane 0 (LSBs) of a row is column 0.
module operand_row_buffer import operands_pkg::*; #(
  parameter  int DATA_WIDTH = OPR_DATA_WIDTH,
  parameter  int BUS_WIDTH  = OPR_BUS_WIDTH,
  localparam int MAX_DIM    = max_dim(DATA_WIDTH, BUS_WIDTH),
  localparam int IDX_W      = $clog2(MAX_DIM)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  i_clr,
  input  logic [MAX_DIM-1:0]    i_cap_en,
  input  logic [BUS_WIDTH-1:0]  i_row_data,
  input  logic [IDX_W-1:0]      i_row,
  input  logic [IDX_W-1:0]      i_col,
  output logic [DATA_WIDTH-1:0] o_elem
);
  logic [BUS_WIDTH-1:0] r_rows [MAX_DIM];
  logic [MAX_DIM*MAX_DIM-1:0][DATA_WIDTH-1:0] w_lane;

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < MAX_DIM; i++) begin
      if (rst_i || i_clr) begin
        r_rows[i] <= '0;
      end else if (i_cap_en[i]) begin
        r_rows[i] <= i_row_data;
      end
    end
  end

  // Flattened (row, col) lane table so the read mux is a single index.
  for (genvar gi = 0; gi < MAX_DIM; gi++) begin : g_row
    for (genvar gj = 0; gj < MAX_DIM; gj++) begin : g_col
      assign w_lane[gi*MAX_DIM + gj] = r_rows[gi][gj*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign o_elem = w_lane[{i_row, i_col}];
endmodule

// File: rtl/operand_reader.sv
// Sweeps the operand store once per start, buffers the first dim rows, checks
// the store's finish flag and streams the dim x dim matrix row-major.
module operand_reader import operands_pkg::*; #(
  parameter  int DATA_WIDTH = OPR_DATA_WIDTH,
  parameter  int BUS_WIDTH  = OPR_BUS_WIDTH,
  localparam int MAX_DIM    = max_dim(DATA_WIDTH, BUS_WIDTH),
  localparam int IDX_W      = $clog2(MAX_DIM),
  localparam int DIM_W      = IDX_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [DIM_W-1:0] dim_i,
  operand_reader_if.master bus,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);
  localparam logic [2:0] S_IDLE   = ST_IDLE;
  localparam logic [2:0] S_FETCH  = ST_FETCH;
  localparam logic [2:0] S_CHECK  = ST_CHECK;
  localparam logic [2:0] S_STREAM = ST_STREAM;
  localparam logic [2:0] S_DONE   = ST_DONE;

  logic [2:0]       r_state;
  logic [DIM_W-1:0] r_dim;
  logic [IDX_W-1:0] r_fcnt;
  logic [IDX_W-1:0] r_row;
  logic [IDX_W-1:0] r_col;
  logic             r_err;

  logic [DIM_W-1:0] w_last;
  logic             w_fetch_last;
  logic             w_col_last;
  logic             w_row_last;
  logic             w_clr;
  logic [MAX_DIM-1:0] w_cap_en;
  logic [DATA_WIDTH-1:0] w_elem;

  assign w_last       = r_dim - DIM_W'(1);
  assign w_fetch_last = (r_fcnt == IDX_W'(MAX_DIM - 1));
  assign w_col_last   = ({1'b0, r_col} == w_last);
  assign w_row_last   = ({1'b0, r_row} == w_last);
  assign w_clr        = (r_state == S_IDLE) && start_i;

  // The sweep always covers every store row; only rows below dim are kept.
  for (genvar gi = 0; gi < MAX_DIM; gi++) begin : g_cap
    assign w_cap_en[gi] = (r_state == S_FETCH) && (r_fcnt == IDX_W'(gi)) &&
                          (DIM_W'(gi) < r_dim);
  end

  operand_row_buffer #(.DATA_WIDTH(DATA_WIDTH), .BUS_WIDTH(BUS_WIDTH)) u_buf (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .i_clr     (w_clr),
    .i_cap_en  (w_cap_en),
    .i_row_data(bus.op_data_i),
    .i_row     (r_row),
    .i_col     (r_col),
    .o_elem    (w_elem)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_dim   <= DIM_W'(MAX_DIM);
      r_fcnt  <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_dim   <= DIM_W'(clamp_dim(32'(dim_i), MAX_DIM));
            r_err   <= 1'b0;
            r_fcnt  <= '0;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (w_fetch_last) begin
            r_fcnt  <= '0;
            r_state <= S_CHECK;
          end else begin
            r_fcnt <= r_fcnt + 1'b1;
          end
        end
        S_CHECK: begin
          if (!bus.finish_send_i) r_err <= 1'b1;
          r_row   <= '0;
          r_col   <= '0;
          r_state <= S_STREAM;
        end
        S_STREAM: begin
          // Terminal compares against dim-1 keep the narrow counters from wrapping.
          if (bus.elem_ready_i) begin
            if (w_col_last) begin
              r_col <= '0;
              if (w_row_last) begin
                r_row   <= '0;
                r_state <= S_DONE;
              end else begin
                r_row <= r_row + 1'b1;
              end
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.start_send_o = (r_state == S_FETCH);
  assign bus.elem_valid_o = (r_state == S_STREAM);
  assign bus.elem_o       = w_elem;
  assign bus.elem_row_o   = r_row;
  assign bus.elem_col_o   = r_col;
  assign busy_o           = (r_state != S_IDLE);
  assign done_o           = (r_state == S_DONE);
  assign err_o            = r_err;
endmodule

// File: tb/tb_operand_reader.sv
// Bench for operand_reader: behavioural store model plus a matrix-level
// reference for element order, completion cycle and error reporting.
module tb_operand_reader;
  localparam int DW   = 32;
  localparam int BW   = 64;
  localparam int MD   = BW / DW;
  localparam int IW   = $clog2(MD);
  localparam int DIMW = IW + 1;
  localparam int IT   = DW + 2*IW;

  logic clk = 1'b0;
  logic rst, start, busy, done, err;
  logic [DIMW-1:0] dim;

  operand_reader_if #(.DATA_WIDTH(DW), .BUS_WIDTH(BW)) bus ();

  operand_reader #(.DATA_WIDTH(DW), .BUS_WIDTH(BW)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .dim_i(dim),
    .bus(bus), .busy_o(busy), .done_o(done), .err_o(err)
  );

  always #5 clk = ~clk;

  int gcyc = 0;
  always @(posedge clk) gcyc <= gcyc + 1;

  // Store model: sequential send pointer, finish flag after a full sweep.
  logic [BW-1:0] mem [MD];
  int   ptr = 0;
  logic st_fin;
  logic fin_force;
  always @(posedge clk) begin
    if (rst) begin
      ptr    <= 0;
      st_fin <= 1'b0;
    end else if (bus.start_send_o) begin
      st_fin <= (ptr == MD - 1);
      ptr    <= (ptr + 1) % MD;
    end
  end
  assign bus.op_data_i     = mem[ptr];
  assign bus.finish_send_i = st_fin & ~fin_force;

  int total = 0, passed = 0;

  // Per-run observations
  bit            rdy_pat [256];
  int            n_obs, done_cyc, done_abs, ss_first, ss_first_abs, ss_last, ss_cnt;
  int            stall_bad;
  bit            timeout;
  logic          err_fv, err_c1, err_done;
  logic [IT-1:0] obs_item [64];

  // Reference
  int            exp_n, exp_done;
  logic [IT-1:0] exp_item [64];

  task automatic set_ready(input int mode);
    for (int i = 0; i < 256; i++)
      rdy_pat[i] = (mode == 0) ? 1'b1 : (mode == 1) ? bit'(i % 2) : bit'($urandom_range(0, 1));
  endtask

  task automatic model(input int dimv);
    int eff, need, cnt;
    logic [BW-1:0] row;
    eff   = (dimv == 0 || dimv > MD) ? MD : dimv;
    exp_n = 0;
    for (int r = 0; r < eff; r++) begin
      row = mem[r];
      for (int c = 0; c < eff; c++) begin
        exp_item[exp_n] = {row[c*DW +: DW], IW'(r), IW'(c)};
        exp_n++;
      end
    end
    need = eff * eff;
    cnt = 0;
    exp_done = -1;
    for (int n = MD + 2; n < 256 && exp_done < 0; n++) begin
      if (rdy_pat[n]) cnt++;
      if (cnt == need) exp_done = n + 1;
    end
  endtask

  task automatic run_txn(input int dimv, input bit pulse);
    int n;
    bit hold, seen_valid;
    logic [IT-1:0] cur, prev;
    n_obs = 0; done_cyc = -1; done_abs = -1; ss_first = -1; ss_first_abs = -1;
    ss_last = -1; ss_cnt = 0; stall_bad = 0; timeout = 0; hold = 0; seen_valid = 0;
    err_fv = 1'bx; err_c1 = 1'bx; err_done = 1'bx; prev = '0;
    @(negedge clk);
    start = 1'b1; dim = DIMW'(dimv); bus.elem_ready_i = rdy_pat[0];
    @(posedge clk);
    n = 1;
    while (1) begin
      @(negedge clk);
      start = 1'b0;
      bus.elem_ready_i = rdy_pat[n];
      if (n == 1) err_c1 = err;
      if (bus.start_send_o) begin
        if (ss_first < 0) begin ss_first = n; ss_first_abs = gcyc; end
        ss_last = n; ss_cnt++;
      end
      if (bus.elem_valid_o) begin
        cur = {bus.elem_o, bus.elem_row_o, bus.elem_col_o};
        if (!seen_valid) begin err_fv = err; seen_valid = 1; end
        if (hold && cur !== prev) stall_bad++;
        if (rdy_pat[n] && n_obs < 64) begin obs_item[n_obs] = cur; n_obs++; end
        hold = !rdy_pat[n];
        prev = cur;
      end else begin
        hold = 0;
      end
      if (pulse && (bus.elem_valid_o || done)) start = 1'b1;
      if (done) begin done_cyc = n; done_abs = gcyc; err_done = err; break; end
      if (n >= 200) begin timeout = 1; break; end
      @(posedge clk);
      n++;
    end
  endtask

  task automatic load_directed();
    mem[0] = 64'h00000002_00000001;
    mem[1] = 64'h00000004_00000003;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; dim = '0; fin_force = 1'b0; bus.elem_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (bus.start_send_o !== 1'b0) $display("FAIL reset_start_send got %b want 0", bus.start_send_o); else passed++;
    total++; if (bus.elem_valid_o !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.elem_valid_o); else passed++;
    total++; if (bus.elem_o !== '0) $display("FAIL reset_elem got %h want 0", bus.elem_o); else passed++;
    total++; if ({bus.elem_row_o, bus.elem_col_o} !== '0) $display("FAIL reset_rowcol got %b want 0", {bus.elem_row_o, bus.elem_col_o}); else passed++;
    total++; if ({busy, done, err} !== 3'b000) $display("FAIL reset_status got %b want 000", {busy, done, err}); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_full();
    load_directed(); set_ready(0); model(2); run_txn(2, 0);
    total++; if (timeout) $display("FAIL full_timeout no done_o within budget"); else passed++;
    total++; if (ss_first !== 1 || ss_last !== MD || ss_cnt !== MD) $display("FAIL full_start_send got first %0d last %0d cnt %0d want 1 %0d %0d", ss_first, ss_last, ss_cnt, MD, MD); else passed++;
    total++; if (n_obs !== exp_n) $display("FAIL full_count got %0d want %0d", n_obs, exp_n); else passed++;
    for (int i = 0; i < exp_n && i < n_obs; i++) begin
      total++; if (obs_item[i] !== exp_item[i]) $display("FAIL full_elem[%0d] got %h want %h", i, obs_item[i], exp_item[i]); else passed++;
    end
    total++; if (done_cyc !== exp_done) $display("FAIL full_done_cycle got %0d want %0d", done_cyc, exp_done); else passed++;
    total++; if (err_fv !== 1'b0 || err_done !== 1'b0) $display("FAIL full_err got %b/%b want 0/0", err_fv, err_done); else passed++;
    $display("txn full: dim=2 elems=%0d done_cycle=%0d", n_obs, done_cyc);
  endtask

  task automatic test_partial();
    load_directed(); set_ready(0); model(1); run_txn(1, 0);
    total++; if (timeout) $display("FAIL partial_timeout no done_o within budget"); else passed++;
    total++; if (ss_cnt !== MD) $display("FAIL partial_start_send_cnt got %0d want %0d", ss_cnt, MD); else passed++;
    total++; if (n_obs !== 1 || obs_item[0] !== exp_item[0]) $display("FAIL partial_elem got n=%0d %h want n=1 %h", n_obs, obs_item[0], exp_item[0]); else passed++;
    total++; if (done_cyc !== exp_done) $display("FAIL partial_done_cycle got %0d want %0d", done_cyc, exp_done); else passed++;
    $display("txn partial: dim=1 elems=%0d done_cycle=%0d", n_obs, done_cyc);
  endtask

  task automatic test_backpressure();
    load_directed(); set_ready(1); model(2); run_txn(2, 0);
    total++; if (timeout) $display("FAIL bp_timeout no done_o within budget"); else passed++;
    total++; if (stall_bad !== 0) $display("FAIL bp_stable got %0d changes want 0", stall_bad); else passed++;
    total++; if (n_obs !== exp_n) $display("FAIL bp_count got %0d want %0d", n_obs, exp_n); else passed++;
    for (int i = 0; i < exp_n && i < n_obs; i++) begin
      total++; if (obs_item[i] !== exp_item[i]) $display("FAIL bp_elem[%0d] got %h want %h", i, obs_item[i], exp_item[i]); else passed++;
    end
    total++; if (done_cyc !== exp_done) $display("FAIL bp_done_cycle got %0d want %0d", done_cyc, exp_done); else passed++;
    $display("txn backpressure: elems=%0d done_cycle=%0d", n_obs, done_cyc);
  endtask

  task automatic test_missing_finish();
    load_directed(); set_ready(0); model(2);
    fin_force = 1'b1;
    run_txn(2, 0);
    fin_force = 1'b0;
    total++; if (err_fv !== 1'b1) $display("FAIL nofin_err_after_check got %b want 1", err_fv); else passed++;
    total++; if (n_obs !== exp_n) $display("FAIL nofin_count got %0d want %0d", n_obs, exp_n); else passed++;
    for (int i = 0; i < exp_n && i < n_obs; i++) begin
      total++; if (obs_item[i] !== exp_item[i]) $display("FAIL nofin_elem[%0d] got %h want %h", i, obs_item[i], exp_item[i]); else passed++;
    end
    @(negedge clk);
    total++; if (err !== 1'b1) $display("FAIL nofin_err_hold got %b want 1", err); else passed++;
    run_txn(2, 0);
    total++; if (err_c1 !== 1'b0 || err_fv !== 1'b0) $display("FAIL nofin_err_clear got %b/%b want 0/0", err_c1, err_fv); else passed++;
    $display("txn missing_finish: elems=%0d err_cleared=%b", n_obs, ~err_c1);
  endtask

  task automatic test_reset_mid();
    int dones, busies;
    load_directed(); set_ready(0);
    @(negedge clk); start = 1'b1; dim = 2'd2;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++; if (bus.start_send_o !== 1'b1) $display("FAIL rstmid_fetch2 got %b want 1", bus.start_send_o); else passed++;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    total++; if ({bus.start_send_o, bus.elem_valid_o, busy, done, err} !== 5'b0) $display("FAIL rstmid_ctrl got %b want 00000", {bus.start_send_o, bus.elem_valid_o, busy, done, err}); else passed++;
    total++; if ({bus.elem_o, bus.elem_row_o, bus.elem_col_o} !== '0) $display("FAIL rstmid_elem got %h want 0", {bus.elem_o, bus.elem_row_o, bus.elem_col_o}); else passed++;
    dones = 0; busies = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) dones++;
      if (busy) busies++;
    end
    total++; if (dones !== 0 || busies !== 0) $display("FAIL rstmid_quiet got done=%0d busy=%0d want 0 0", dones, busies); else passed++;
    $display("txn reset_mid: quiet after reset dones=%0d", dones);
  endtask

  task automatic test_ignored_start();
    load_directed(); set_ready(0); model(2); run_txn(2, 1);
    total++; if (n_obs !== exp_n) $display("FAIL ign_count got %0d want %0d", n_obs, exp_n); else passed++;
    for (int i = 0; i < exp_n && i < n_obs; i++) begin
      total++; if (obs_item[i] !== exp_item[i]) $display("FAIL ign_elem[%0d] got %h want %h", i, obs_item[i], exp_item[i]); else passed++;
    end
    total++; if (done_cyc !== exp_done) $display("FAIL ign_done_cycle got %0d want %0d", done_cyc, exp_done); else passed++;
    @(negedge clk); start = 1'b0;
    total++; if (busy !== 1'b0) $display("FAIL ign_idle_after got busy=%b want 0", busy); else passed++;
    $display("txn ignored_start: elems=%0d done_cycle=%0d", n_obs, done_cyc);
  endtask

  task automatic test_clamp();
    int dv [2];
    dv[0] = 0; dv[1] = 3;
    for (int k = 0; k < 2; k++) begin
      load_directed(); set_ready(0); model(dv[k]); run_txn(dv[k], 0);
      total++; if (n_obs !== 4) $display("FAIL clamp%0d_count got %0d want 4", dv[k], n_obs); else passed++;
      total++; if (obs_item[3] !== exp_item[3]) $display("FAIL clamp%0d_last got %h want %h", dv[k], obs_item[3], exp_item[3]); else passed++;
      total++; if (done_cyc !== exp_done) $display("FAIL clamp%0d_done_cycle got %0d want %0d", dv[k], done_cyc, exp_done); else passed++;
      $display("txn clamp: dim_i=%0d elems=%0d", dv[k], n_obs);
    end
  endtask

  task automatic test_back_to_back();
    int prev_done;
    load_directed(); set_ready(0);
    run_txn(2, 0);
    prev_done = done_abs;
    run_txn(1, 0);
    total++; if (ss_first_abs !== prev_done + 2) $display("FAIL b2b_fetch_start got %0d want %0d", ss_first_abs, prev_done + 2); else passed++;
    total++; if (n_obs !== 1) $display("FAIL b2b_count got %0d want 1", n_obs); else passed++;
    $display("txn back_to_back: second fetch at %0d after done at %0d", ss_first_abs, prev_done);
  endtask

  task automatic test_random();
    int dv, bad;
    for (int t = 0; t < 8; t++) begin
      for (int r = 0; r < MD; r++) mem[r] = {$urandom, $urandom};
      dv = $urandom_range(0, MD + 1);
      set_ready(2); model(dv); run_txn(dv, 0);
      bad = 0;
      for (int i = 0; i < exp_n && i < n_obs; i++) if (obs_item[i] !== exp_item[i]) bad++;
      total++; if (timeout || n_obs !== exp_n || bad !== 0) $display("FAIL rand%0d_stream got n=%0d bad=%0d want n=%0d bad=0", t, n_obs, bad, exp_n); else passed++;
      total++; if (done_cyc !== exp_done || stall_bad !== 0) $display("FAIL rand%0d_timing got done=%0d stall=%0d want %0d 0", t, done_cyc, stall_bad, exp_done); else passed++;
      $display("txn random%0d: dim_i=%0d elems=%0d done_cycle=%0d", t, dv, n_obs, done_cyc);
    end
  endtask

  initial begin
    load_directed();
    test_reset();
    test_full();
    test_partial();
    test_backpressure();
    test_missing_finish();
    test_reset_mid();
    test_ignored_start();
    test_clamp();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
